led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
Controller that drives the one-cycle `signal` advance input of the RGB LED colour-cycling interface. It shares that single advance resource between three requesters: a debounced manual step button, an internal auto-cycle timer and an external synchronous requester (e.g. UART/command logic). A mode FSM selects the requesters that are active, and fixed-priority arbitration grants at most one advance per cycle.

Parameters:
DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a new button level (20 ms at 12 MHz)
AUTO_PERIOD, 6000000, cycles between auto advances in AUTO mode (0.5 s at 12 MHz); must be >= 2
CNT_W, 24, width of the debounce and period counters; must hold max(DEBOUNCE_CYCLES, AUTO_PERIOD)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
btn_step  in  1  raw asynchronous step button, 1 = pressed
btn_mode  in  1  raw asynchronous mode button, 1 = pressed
ext_req  in  1  synchronous request level from the external requester
ext_gnt  out  1  one-cycle grant pulse to the external requester
advance  out  1  one-cycle pulse to the LED interface `signal` input
mode  out  2  current mode: 0 MANUAL, 1 AUTO, 2 PAUSE
step_count  out  8  total advances issued, wraps 255 -> 0

Behaviour:
- Reset (reset = 0, asynchronous): advance = 0, ext_gnt = 0, mode = MANUAL, step_count = 0, period counter = 0, auto_pending = 0. Synchronisers and debounced levels clear to 0. Reset asserted mid-operation aborts everything, and no advance is issued for a request in flight.
- Buttons: each button passes through a 2-flop synchroniser and then a debouncer. The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles in which the synchronised input differs from the current debounced level. A shorter glitch restarts the count. A rising edge of the debounced level produces one event pulse (step_evt or mode_evt). A button held through reset release produces one event after debounce.
- Mode FSM: on mode_evt the mode steps MANUAL -> AUTO -> PAUSE -> MANUAL. Every mode change clears the period counter and auto_pending.
- Period counter: in AUTO it counts 0 .. AUTO_PERIOD-1. At terminal count it raises auto_tick for one cycle and wraps to 0. In PAUSE it holds its value. In MANUAL it stays at 0.
- Requests and priority (highest first):
  1. step_evt, accepted in all modes. In AUTO it also clears the period counter, and an auto_tick in the same cycle is dropped.
  2. auto_tick or auto_pending.
  3. ext_req.
- Losing auto_tick: sets auto_pending, which is served on the next free cycle.
- ext handshake: ext_req is held high until the requester sees ext_gnt. The requester drops ext_req in the cycle after ext_gnt.
- Grant timing: the winner is arbitrated in cycle N, and advance is registered high in cycle N+1. For ext_req, ext_gnt is high in the same cycle N+1. Never more than one advance per cycle.
- step_count: increments on every advance and wraps modulo 256.
- Simultaneous mode_evt and step_evt: both take effect. The step advances, and the mode changes and clears the counter.

Optional Feature:
LED_SEQ_HEARTBEAT_EN
- Defined: adds output `heartbeat` (1 bit, reset value 0), which toggles on every advance pulse. It mirrors the LED interface test LED and is used for board bring-up.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package led_seq_pkg:
  - mode encodings MODE_MANUAL = 2'd0, MODE_AUTO = 2'd1, MODE_PAUSE = 2'd2
  - default DEBOUNCE_CYCLES, AUTO_PERIOD and CNT_W constants
- Sub-module btn_debounce contains the synchroniser, debounce counter and rising-edge event. It is instantiated twice, for step and mode. The FSM, period counter, arbiter and step counter stay in led_sequencer.

Test Plan (DEBOUNCE_CYCLES = 4, AUTO_PERIOD = 8):
- Reset: reset = 0 with buttons toggling -> advance = 0, ext_gnt = 0, mode = 0, step_count = 0 throughout. Release -> no advance while inputs are idle.
- Debounce: btn_step high 2 cycles then low -> no advance. btn_step high 10 cycles -> exactly one advance pulse, step_count = 1.
- Mode cycling:
  - mode press -> mode = 1, advance every 8 cycles (3 pulses in 24 cycles).
  - Second press -> mode = 2, zero advances over 40 cycles.
  - Third press -> mode = 0.
- Collision: in AUTO, ext_req rises in the auto_tick cycle -> advance for auto in N+1, then ext_gnt and advance in N+2. step_count increases by 2.
- Step vs auto: step_evt coincides with auto_tick -> one advance, period counter restarts, next auto advance 8 cycles later.
- Async reset mid-AUTO: reset pulled low between edges -> outputs 0 immediately. After release, mode = 0 and a 256-grant ext_req burst returns step_count to 0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared mode encodings, default timing constants and the mode-stepping helper
// for the LED sequencer.
package led_seq_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_PAUSE  = 2'd2;

  localparam int DEBOUNCE_CYCLES_DEF = 240000;
  localparam int AUTO_PERIOD_DEF     = 6000000;
  localparam int CNT_W_DEF           = 24;

  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    case (cur)
      MODE_MANUAL: next_mode = MODE_AUTO;
      MODE_AUTO:   next_mode = MODE_PAUSE;
      default:     next_mode = MODE_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-level debouncer and rising-edge event pulse
// for one raw push button.
module btn_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Any cycle that agrees with the accepted level restarts the stability count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      evt    <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      evt    <= 1'b0;
      if (sync_b != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_b;
          cnt   <= '0;
          evt   <= sync_b;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Shares the LED interface advance pulse between the step button, auto timer
// and external requester. Optional `heartbeat` output under LED_SEQ_HEARTBEAT_EN.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int AUTO_PERIOD     = AUTO_PERIOD_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_step,
  input  logic       btn_mode,
  input  logic       ext_req,
  output logic       ext_gnt,
  output logic       advance,
  output logic [1:0] mode,
  output logic [7:0] step_count
`ifdef LED_SEQ_HEARTBEAT_EN
  ,
  output logic       heartbeat
`endif
);

  logic             step_evt;
  logic             mode_evt;
  logic [CNT_W-1:0] period_cnt;
  logic             auto_pending;
  logic             auto_tick;
  logic             auto_want;
  logic             win_step;
  logic             win_auto;
  logic             win_ext;
  logic             win_any;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_step_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_step),
    .evt   (step_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mode_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_mode),
    .evt   (mode_evt)
  );

  // Fixed priority: step, then auto, then external. The external request is
  // masked while its grant is out because the requester only drops it a cycle later.
  assign auto_tick = (mode == MODE_AUTO) && (period_cnt == CNT_W'(AUTO_PERIOD - 1));
  assign auto_want = auto_tick || auto_pending;
  assign win_step  = step_evt;
  assign win_auto  = !step_evt && auto_want;
  assign win_ext   = !step_evt && !auto_want && ext_req && !ext_gnt;
  assign win_any   = win_step || win_auto || win_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode         <= MODE_MANUAL;
      period_cnt   <= '0;
      auto_pending <= 1'b0;
    end else if (mode_evt) begin
      mode         <= next_mode(mode);
      period_cnt   <= '0;
      auto_pending <= 1'b0;
    end else begin
      case (mode)
        MODE_AUTO: begin
          if (step_evt || auto_tick) period_cnt <= '0;
          else                       period_cnt <= period_cnt + CNT_W'(1);
        end
        MODE_PAUSE: period_cnt <= period_cnt;
        default:    period_cnt <= '0;
      endcase
      // A step in the tick cycle swallows the tick rather than deferring it.
      if (win_auto)                    auto_pending <= 1'b0;
      else if (auto_tick && !step_evt) auto_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      advance    <= 1'b0;
      ext_gnt    <= 1'b0;
      step_count <= 8'd0;
    end else begin
      advance <= win_any;
      ext_gnt <= win_ext;
      if (win_any) step_count <= step_count + 8'd1;
    end
  end

`ifdef LED_SEQ_HEARTBEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       heartbeat <= 1'b0;
    else if (win_any) heartbeat <= ~heartbeat;
  end
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_mode = 1'b0;
  logic       ext_req = 1'b0;
  logic       ext_gnt;
  logic       advance;
  logic [1:0] mode;
  logic [7:0] step_count;
`ifdef LED_SEQ_HEARTBEAT_EN
  logic       heartbeat;
`endif

  typedef struct {
    logic       ext;
    logic [7:0] count;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] exp_count = 8'd0;
  int         total = 0;
  int         bad = 0;
  int         cnt, first, second, grants, cyc, ph;

  always #5 clk = ~clk;

  led_sequencer #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8), .CNT_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_step   (btn_step),
    .btn_mode   (btn_mode),
    .ext_req    (ext_req),
    .ext_gnt    (ext_gnt),
    .advance    (advance),
    .mode       (mode),
    .step_count (step_count)
`ifdef LED_SEQ_HEARTBEAT_EN
    ,
    .heartbeat  (heartbeat)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic void pushExp(input logic ext);
    exp_t e;
    exp_count = exp_count + 8'd1;
    e.ext     = ext;
    e.count   = exp_count;
    exp_q.push_back(e);
  endfunction

  // which: 0 = step button, 1 = mode button
  task automatic applyStimulus(input int which, input int hold);
    if (which == 0) btn_step = 1'b1;
    else            btn_mode = 1'b1;
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    btn_mode = 1'b0;
  endtask

  task automatic countAdvances(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (advance) c++;
    end
  endtask

  task automatic waitAdvance(input string tag, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!advance && n < limit);
    checkOutput(tag, 32'(advance), 32'd1);
  endtask

  // Every advance pulse is matched against the oldest expected grant.
  always @(negedge clk) begin
    if (reset && (advance || ext_gnt)) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_adv", {30'd0, ext_gnt, advance}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("adv_pulse", 32'(advance), 32'd1);
        checkOutput("adv_gnt", 32'(ext_gnt), 32'(mon_e.ext));
        checkOutput("adv_count", 32'(step_count), 32'(mon_e.count));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_step = i[0];
      btn_mode = ~i[0];
      ext_req  = i[1];
      @(posedge clk);
      #2;
      checkOutput("rst_adv", 32'(advance), 32'd0);
      checkOutput("rst_gnt", 32'(ext_gnt), 32'd0);
      checkOutput("rst_mode", 32'(mode), 32'd0);
      checkOutput("rst_count", 32'(step_count), 32'd0);
    end
    @(negedge clk);
    btn_step = 1'b0;
    btn_mode = 1'b0;
    ext_req  = 1'b0;
    reset    = 1'b1;
    countAdvances(20, cnt);
    checkOutput("idle_after_reset", 32'(cnt), 32'd0);

    applyStimulus(0, 2);
    countAdvances(15, cnt);
    checkOutput("glitch_ignored", 32'(cnt), 32'd0);

    pushExp(1'b0);
    applyStimulus(0, 10);
    countAdvances(15, cnt);
    checkOutput("press_count", 32'(step_count), 32'd1);

    pushExp(1'b0);
    applyStimulus(1, 10);
    checkOutput("mode_auto", 32'(mode), 32'd1);
    waitAdvance("auto_first", 20);
    repeat (3) pushExp(1'b0);
    countAdvances(24, cnt);
    checkOutput("auto_3_in_24", 32'(cnt), 32'd3);

    applyStimulus(1, 10);
    checkOutput("mode_pause", 32'(mode), 32'd2);
    countAdvances(40, cnt);
    checkOutput("pause_quiet", 32'(cnt), 32'd0);
    applyStimulus(1, 10);
    checkOutput("mode_manual", 32'(mode), 32'd0);
    countAdvances(10, cnt);
    checkOutput("manual_quiet", 32'(cnt), 32'd0);

    // ext_req rises in the auto_tick cycle: auto first, ext right after.
    pushExp(1'b0);
    applyStimulus(1, 10);
    checkOutput("mode_auto2", 32'(mode), 32'd1);
    waitAdvance("coll_sync", 20);
    repeat (7) @(negedge clk);
    ext_req = 1'b1;
    pushExp(1'b0);
    pushExp(1'b1);
    @(negedge clk);
    checkOutput("coll_auto_adv", 32'(advance), 32'd1);
    checkOutput("coll_auto_gnt", 32'(ext_gnt), 32'd0);
    @(negedge clk);
    checkOutput("coll_ext_adv", 32'(advance), 32'd1);
    checkOutput("coll_ext_gnt", 32'(ext_gnt), 32'd1);
    @(negedge clk);
    checkOutput("coll_no_regrant", 32'(advance), 32'd0);
    ext_req = 1'b0;
    checkOutput("coll_count", 32'(step_count), 32'(exp_count));

    // step_evt lands in the auto_tick cycle.
    pushExp(1'b0);
    waitAdvance("sva_sync", 10);
    @(negedge clk);
    btn_step = 1'b1;
    pushExp(1'b0);
    pushExp(1'b0);
    first  = -1;
    second = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) btn_step = 1'b0;
      if (advance) begin
        if (first < 0)       first = i;
        else if (second < 0) second = i;
      end
    end
    checkOutput("sva_step_slot", 32'(first), 32'd7);
    checkOutput("sva_gap", 32'(second - first), 32'd8);

    pushExp(1'b0);
    waitAdvance("rst_sync", 12);
    #1 reset = 1'b0;
    #1;
    checkOutput("async_rst_adv", 32'(advance), 32'd0);
    checkOutput("async_rst_mode", 32'(mode), 32'd0);
    checkOutput("async_rst_count", 32'(step_count), 32'd0);
    checkOutput("async_rst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_count = 8'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_mode", 32'(mode), 32'd0);

    for (int i = 0; i < 256; i++) pushExp(1'b1);
    ext_req = 1'b1;
    grants  = 0;
    cyc     = 0;
    ph      = 0;
    while (grants < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (ph == 1) begin
        ext_req = 1'b0;
        ph = 2;
      end else if (ph == 2) begin
        ext_req = 1'b1;
        ph = 0;
      end else if (ext_gnt) begin
        grants++;
        ph = 1;
      end
    end
    ext_req = 1'b0;
    checkOutput("burst_grants", 32'(grants), 32'd256);
    checkOutput("burst_wrap", 32'(step_count), 32'd0);
    countAdvances(5, cnt);
    checkOutput("burst_tail_quiet", 32'(cnt), 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef LED_SEQ_HEARTBEAT_EN
    checkOutput("heartbeat_parity", 32'(heartbeat), 32'(step_count[0]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
